switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 111 +++++++++++
 tb/tb_switch_allocator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among idle requesters, lock held until the TAIL flit.
// Grants are combinational from state and requests; a cleared credit_ok_i withholds the grant and freezes that output's state.
module switch_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORT_NUM-1:0]                 req_valid_i,
  input  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  req_port_i,
  input  logic [PORT_NUM-1:0]                 req_tail_i,
  input  logic [PORT_NUM-1:0]                 credit_ok_i,
  output logic [PORT_NUM-1:0]                 grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]  xbar_sel_o,
  output logic [PORT_NUM-1:0]                 xbar_valid_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q [PORT_NUM];
  state_t               state_d [PORT_NUM];
  logic [PORT_SIZE-1:0] owner_q [PORT_NUM];
  logic [PORT_SIZE-1:0] owner_d [PORT_NUM];
  logic [PORT_SIZE-1:0] ptr_q   [PORT_NUM];
  logic [PORT_SIZE-1:0] ptr_d   [PORT_NUM];

  logic [PORT_NUM-1:0]  req_mat [PORT_NUM];
  logic [PORT_NUM-1:0]  win_vld;
  logic [PORT_SIZE-1:0] win_idx [PORT_NUM];

  // req_mat[o][i]: input i wants output o; out-of-range port numbers never match
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        req_mat[o][i] = req_valid_i[i] && (req_port_i[i] == PORT_SIZE'(o));
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    win_vld = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win_idx[o] = '0;
      if (credit_ok_i[o]) begin
        if (state_q[o] == LOCKED) begin
          if (req_mat[o][owner_q[o]]) begin
            win_vld[o] = 1'b1;
            win_idx[o] = owner_q[o];
          end
        end else begin
          // Scan in reverse priority so the last hit is the first requester after ptr.
          for (int k = PORT_NUM - 1; k >= 0; k--) begin
            idx = int'(ptr_q[o]) + k;
            if (idx >= PORT_NUM) idx = idx - PORT_NUM;
            if (req_mat[o][idx]) begin
              win_vld[o] = 1'b1;
              win_idx[o] = PORT_SIZE'(idx);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (win_vld[o]) begin
        if (state_q[o] == IDLE) begin
          ptr_d[o] = (win_idx[o] == PORT_SIZE'(PORT_NUM - 1)) ? '0 : win_idx[o] + PORT_SIZE'(1);
          if (!req_tail_i[win_idx[o]]) begin
            state_d[o] = LOCKED;
            owner_d[o] = win_idx[o];
          end
        end else if (req_tail_i[win_idx[o]]) begin
          state_d[o] = IDLE;
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      xbar_valid_o[o] = win_vld[o];
      xbar_sel_o[o]   = win_vld[o] ? win_idx[o] : '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (win_vld[o] && (win_idx[o] == PORT_SIZE'(i))) grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboarded bench for switch_allocator with PORT_NUM=5: directed packet scenarios then randomized traffic.
module tb_switch_allocator;
  localparam int N = 5;
  localparam int S = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][S-1:0] req_port  = '0;
  logic [N-1:0]        req_tail  = '0;
  logic [N-1:0]        credit_ok = '0;
  logic [N-1:0]        grant;
  logic [N-1:0][S-1:0] xbar_sel;
  logic [N-1:0]        xbar_valid;

  int n_chk  = 0;
  int n_fail = 0;
  logic [24:0] sb_q [$];
  int m_lock [N];
  int m_owner[N];
  int m_ptr  [N];
  logic [N-1:0] obs_g, obs_v;
  logic [14:0]  obs_s;

  always #5 clk = ~clk;

  switch_allocator #(.PORT_NUM(N), .PORT_SIZE(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_port_i   (req_port),
    .req_tail_i   (req_tail),
    .credit_ok_i  (credit_ok),
    .grant_o      (grant),
    .xbar_sel_o   (xbar_sel),
    .xbar_valid_o (xbar_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pp(input int a0, input int a1, input int a2, input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o]  = 0;
      m_owner[o] = 0;
      m_ptr[o]   = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    req_tail  = '0;
    req_port  = '0;
    credit_ok = '1;
    model_reset();
    #2;
    check("rst_gnt", 32'(grant), 32'h0);
    check("rst_vld", 32'(xbar_valid), 32'h0);
    check("rst_sel", 32'(xbar_sel), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare against the DUT.
  task automatic step(input string tag, input logic [4:0] v, input logic [14:0] p,
                      input logic [4:0] t, input logic [4:0] c);
    logic [4:0]  eg, ev;
    logic [14:0] es;
    logic [24:0] e;
    int win, ow, cc;
    @(negedge clk);
    req_valid = v;
    req_port  = p;
    req_tail  = t;
    credit_ok = c;
    eg = '0;
    ev = '0;
    es = '0;
    for (int o = 0; o < N; o++) begin
      win = -1;
      if (c[o]) begin
        if (m_lock[o] != 0) begin
          ow = m_owner[o];
          if (v[ow] && int'(p[ow*3 +: 3]) == o) win = ow;
        end else begin
          for (int k = 0; k < N; k++) begin
            cc = (m_ptr[o] + k) % N;
            if (win < 0 && v[cc] && int'(p[cc*3 +: 3]) == o) win = cc;
          end
        end
      end
      if (win >= 0) begin
        eg[win] = 1'b1;
        ev[o]   = 1'b1;
        es[o*3 +: 3] = 3'(win);
        if (m_lock[o] == 0) begin
          m_ptr[o] = (win + 1) % N;
          if (!t[win]) begin
            m_lock[o]  = 1;
            m_owner[o] = win;
          end
        end else if (t[win]) begin
          m_lock[o] = 0;
        end
      end
    end
    sb_q.push_back({eg, ev, es});
    #2;
    obs_g = grant;
    obs_v = xbar_valid;
    obs_s = xbar_sel;
    e = sb_q.pop_front();
    check({tag, "_gnt"}, 32'(obs_g), 32'(e[24:20]));
    check({tag, "_vld"}, 32'(obs_v), 32'(e[19:15]));
    check({tag, "_sel"}, 32'(obs_s), 32'(e[14:0]));
  endtask

  initial begin
    logic [4:0]  rv, rt, rc;
    logic [14:0] rp;

    do_reset();

    // Single-flit from input 2 to output 1, then ptr[1]=3 favours input 3 over 2.
    step("r26", 5'b00100, pp(0, 0, 1, 0, 0), 5'b00100, 5'b11111);
    check("r26_gnt_c", 32'(obs_g), 32'h04);
    check("r26_sel1_c", 32'(obs_s[5:3]), 32'd2);
    check("r26_vld_c", 32'(obs_v), 32'h02);
    step("r26b", 5'b01100, pp(0, 0, 1, 1, 0), 5'b01100, 5'b11111);
    check("r26b_gnt_c", 32'(obs_g), 32'h08);

    // Round-robin alternation on output 4.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step("r27", 5'b01001, pp(4, 0, 0, 4, 0), 5'b11111, 5'b11111);
      check("r27_gnt_c", 32'(obs_g), (k % 2 == 0) ? 32'h01 : 32'h08);
    end

    // Four-flit packet from input 1 holds output 0 against input 4.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step("r28", 5'b10010, pp(0, 0, 0, 0, 0), (k == 3) ? 5'b10010 : 5'b10000, 5'b11111);
      check("r28_gnt_c", 32'(obs_g), 32'h02);
    end
    step("r28e", 5'b10000, pp(0, 0, 0, 0, 0), 5'b10000, 5'b11111);
    check("r28e_gnt_c", 32'(obs_g), 32'h10);

    // Credit stall on a locked output 2.
    do_reset();
    step("r29h", 5'b01001, pp(2, 0, 0, 2, 0), 5'b00000, 5'b11111);
    check("r29h_gnt_c", 32'(obs_g), 32'h01);
    for (int k = 0; k < 3; k++) begin
      step("r29s", 5'b01001, pp(2, 0, 0, 2, 0), 5'b00000, 5'b11011);
      check("r29s_gnt_c", 32'(obs_g), 32'h00);
    end
    step("r29t", 5'b01001, pp(2, 0, 0, 2, 0), 5'b00001, 5'b11111);
    check("r29t_gnt_c", 32'(obs_g), 32'h01);
    step("r29n", 5'b01000, pp(0, 0, 0, 2, 0), 5'b01000, 5'b11111);
    check("r29n_gnt_c", 32'(obs_g), 32'h08);

    // Reset mid-packet drops the lock on output 3.
    do_reset();
    step("r30h", 5'b00010, pp(0, 3, 0, 0, 0), 5'b00000, 5'b11111);
    check("r30h_gnt_c", 32'(obs_g), 32'h02);
    do_reset();
    step("r30", 5'b00011, pp(3, 3, 0, 0, 0), 5'b00011, 5'b11111);
    check("r30_gnt_c", 32'(obs_g), 32'h01);

    // Out-of-range port numbers are never granted.
    step("r31", 5'b00001, pp(6, 0, 0, 0, 0), 5'b00001, 5'b11111);
    check("r31_gnt_c", 32'(obs_g), 32'h00);
    check("r31_vld_c", 32'(obs_v), 32'h00);
    step("r31b", 5'b11111, pp(5, 6, 7, 5, 6), 5'b11111, 5'b11111);
    check("r31b_gnt_c", 32'(obs_g), 32'h00);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 96) do_reset();
      rv = 5'($urandom);
      rt = 5'($urandom);
      rc = 5'($urandom | $urandom);
      rp = '0;
      for (int i = 0; i < N; i++) rp[i*3 +: 3] = 3'($urandom_range(0, 5));
      step("rnd", rv, rp, rt, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
